// File: rtl/smem_pkg.sv
// smem_pkg: shared store-entry layout and request encodings for the backward-extension store arbiter.
package smem_pkg;
    localparam int SMEM_ADDR_W = 7;
    localparam int STORE_ENTRY_W = SMEM_ADDR_W + 256;
    localparam logic REQ_MEM = 1'b0;
    localparam logic REQ_CURR = 1'b1;

    typedef struct packed {
        logic [SMEM_ADDR_W-1:0] addr;
        logic [63:0] x0;
        logic [63:0] x1;
        logic [63:0] x2;
        logic [63:0] info;
    } store_entry_t;

    function automatic store_entry_t pack_entry(
        input logic [SMEM_ADDR_W-1:0] addr,
        input logic [63:0] x0,
        input logic [63:0] x1,
        input logic [63:0] x2,
        input logic [63:0] info
    );
        return '{addr: addr, x0: x0, x1: x1, x2: x2, info: info};
    endfunction

    function automatic logic [255:0] entry_data(input store_entry_t e);
        return {e.x0, e.x1, e.x2, e.info};
    endfunction
endpackage

// File: rtl/store_fifo.sv
// store_fifo: small per-requester FIFO; a push on a full FIFO is accepted only when a pop frees a slot the same cycle.
module store_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 263
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic do_push, do_pop;

    always_comb begin
        full = count == CW'(DEPTH);
        empty = count == '0;
        do_pop = pop && !empty;
        do_push = push && (!full || do_pop);
        dout = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/bck_store_arbiter.sv
// bck_store_arbiter: round-robin merge of mem/curr token stores onto one registered RAM write port.
// Define STORE_ARB_PERF_EN to add saturating perf counters (writes, stall cycles, backpressure cycles).
module bck_store_arbiter
    import smem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int STALL_MARGIN = 2,
    parameter int ADDR_W = SMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_push,
    input  logic [63:0]       mem_x0,
    input  logic [63:0]       mem_x1,
    input  logic [63:0]       mem_x2,
    input  logic [63:0]       mem_info,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              curr_push,
    input  logic [63:0]       curr_x0,
    input  logic [63:0]       curr_x1,
    input  logic [63:0]       curr_x2,
    input  logic [63:0]       curr_info,
    input  logic [ADDR_W-1:0] curr_addr,
    output logic              stall,
    output logic              wr_en,
    output logic              wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [255:0]      wr_data,
    input  logic              wr_ready,
    output logic              ovf_err,
    output logic              idle
`ifdef STORE_ARB_PERF_EN
    ,
    output logic [31:0]       perf_writes,
    output logic [31:0]       perf_stall_cyc,
    output logic [31:0]       perf_bp_cyc
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] THR = CW'(DEPTH - STALL_MARGIN);

    store_entry_t mem_din, curr_din, mem_head, curr_head, head;
    logic [CW-1:0] mem_cnt, curr_cnt;
    logic mem_full, mem_empty, curr_full, curr_empty;
    logic mem_pop, curr_pop, adv, any, grant, last_grant;

    assign mem_din = pack_entry(mem_addr, mem_x0, mem_x1, mem_x2, mem_info);
    assign curr_din = pack_entry(curr_addr, curr_x0, curr_x1, curr_x2, curr_info);

    store_fifo #(.DEPTH(DEPTH), .W(STORE_ENTRY_W)) u_mem_fifo (
        .clk(clk), .rst(rst), .push(mem_push), .pop(mem_pop), .din(mem_din),
        .dout(mem_head), .count(mem_cnt), .full(mem_full), .empty(mem_empty)
    );

    store_fifo #(.DEPTH(DEPTH), .W(STORE_ENTRY_W)) u_curr_fifo (
        .clk(clk), .rst(rst), .push(curr_push), .pop(curr_pop), .din(curr_din),
        .dout(curr_head), .count(curr_cnt), .full(curr_full), .empty(curr_empty)
    );

    // On a tie the requester that did not win last time gets the slot.
    always_comb begin
        adv = !wr_en || wr_ready;
        any = !mem_empty || !curr_empty;
        grant = mem_empty ? REQ_CURR : curr_empty ? REQ_MEM : ~last_grant;
        mem_pop = adv && !mem_empty && grant == REQ_MEM;
        curr_pop = adv && !curr_empty && grant == REQ_CURR;
        head = grant == REQ_CURR ? curr_head : mem_head;
        stall = mem_cnt >= THR || curr_cnt >= THR;
        idle = mem_empty && curr_empty && !wr_en;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_en <= 1'b0;
            wr_sel <= REQ_MEM;
            wr_addr <= '0;
            wr_data <= '0;
            last_grant <= REQ_CURR;
            ovf_err <= 1'b0;
        end else begin
            if (adv) begin
                wr_en <= any;
                if (any) begin
                    wr_sel <= grant;
                    wr_addr <= head.addr;
                    wr_data <= entry_data(head);
                    last_grant <= grant;
                end
            end
            if ((mem_push && mem_full && !mem_pop) || (curr_push && curr_full && !curr_pop)) ovf_err <= 1'b1;
        end
    end

`ifdef STORE_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_writes <= '0;
            perf_stall_cyc <= '0;
            perf_bp_cyc <= '0;
        end else begin
            if (wr_en && wr_ready && perf_writes != '1) perf_writes <= perf_writes + 1'b1;
            if (stall && perf_stall_cyc != '1) perf_stall_cyc <= perf_stall_cyc + 1'b1;
            if (wr_en && !wr_ready && perf_bp_cyc != '1) perf_bp_cyc <= perf_bp_cyc + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_bck_store_arbiter.sv
// tb_bck_store_arbiter: directed checks of latency, round-robin, stall/overflow, hold, full push+pop and reset.
module tb_bck_store_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mem_push = 1'b0, curr_push = 1'b0;
    logic [63:0] mem_x0 = '0, mem_x1 = '0, mem_x2 = '0, mem_info = '0;
    logic [63:0] curr_x0 = '0, curr_x1 = '0, curr_x2 = '0, curr_info = '0;
    logic [6:0] mem_addr = '0, curr_addr = '0;
    logic wr_ready = 1'b1;
    logic stall, wr_en, wr_sel, ovf_err, idle;
    logic [6:0] wr_addr;
    logic [255:0] wr_data;
`ifdef STORE_ARB_PERF_EN
    logic [31:0] perf_writes, perf_stall_cyc, perf_bp_cyc;
`endif
    int total = 0;
    int bad = 0;

    bck_store_arbiter dut (
        .clk(clk), .rst(rst),
        .mem_push(mem_push), .mem_x0(mem_x0), .mem_x1(mem_x1), .mem_x2(mem_x2),
        .mem_info(mem_info), .mem_addr(mem_addr),
        .curr_push(curr_push), .curr_x0(curr_x0), .curr_x1(curr_x1), .curr_x2(curr_x2),
        .curr_info(curr_info), .curr_addr(curr_addr),
        .stall(stall), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .ovf_err(ovf_err), .idle(idle)
`ifdef STORE_ARB_PERF_EN
        , .perf_writes(perf_writes), .perf_stall_cyc(perf_stall_cyc), .perf_bp_cyc(perf_bp_cyc)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] mk(input logic [6:0] a);
        return {57'h1A0000000000000, a, 57'h1B0000000000000, a, 57'h1C0000000000000, a, 57'h1D0000000000000, a};
    endfunction

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mem(input logic p, input logic [6:0] a);
        mem_push = p;
        mem_addr = a;
        {mem_x0, mem_x1, mem_x2, mem_info} = mk(a);
    endtask

    task automatic set_curr(input logic p, input logic [6:0] a);
        curr_push = p;
        curr_addr = a;
        {curr_x0, curr_x1, curr_x2, curr_info} = mk(a);
    endtask

    task automatic do_reset();
        set_mem(1'b0, 7'd0);
        set_curr(1'b0, 7'd0);
        wr_ready = 1'b1;
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    logic [7:0] seq_exp [6] = '{8'h0A, 8'h94, 8'h0B, 8'h95, 8'h0C, 8'h96};
    logic [7:0] seq_got [6];
    int n;
    logic stall_exp [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic ovf_exp [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic seen;

    initial begin
        #1;
        tick();
        do_reset();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_idle", idle, 1);
        chk("rst_stall", stall, 0);
        chk("rst_ovf", ovf_err, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_data", wr_data, 0);

        // single push latency
        set_mem(1'b1, 7'd5);
        tick();
        set_mem(1'b0, 7'd0);
        chk("lat_n1", wr_en, 0);
        tick();
        chk("lat_n2_en", wr_en, 1);
        chk("lat_n2_sel", wr_sel, 0);
        chk("lat_n2_addr", wr_addr, 5);
        chk("lat_n2_data", wr_data, mk(7'd5));
        tick();
        chk("lat_idle", idle, 1);
        chk("lat_en_off", wr_en, 0);

        // round-robin alternation, sel in bit 7
        do_reset();
        n = 0;
        for (int i = 0; i < 15; i++) begin
            set_mem(i < 3, 7'(10 + i));
            set_curr(i < 3, 7'(20 + i));
            if (wr_en && n < 6) begin
                seq_got[n] = {wr_sel, wr_addr};
                chk($sformatf("rr_data%0d", n), wr_data, mk(wr_addr));
                n++;
            end
            tick();
        end
        chk("rr_count", n, 6);
        for (int k = 0; k < 6; k++) chk($sformatf("rr_seq%0d", k), seq_got[k], seq_exp[k]);
        chk("rr_stall_end", stall, 0);
        chk("rr_idle_end", idle, 1);

        // stall and overflow under backpressure
        do_reset();
        wr_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_curr(1'b1, 7'(30 + i));
            tick();
            chk($sformatf("st_stall%0d", i), stall, stall_exp[i]);
            chk($sformatf("st_ovf%0d", i), ovf_err, ovf_exp[i]);
        end
        set_curr(1'b0, 7'd0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold_en%0d", i), wr_en, 1);
            chk($sformatf("hold_sel%0d", i), wr_sel, 1);
            chk($sformatf("hold_addr%0d", i), wr_addr, 30);
            chk($sformatf("hold_data%0d", i), wr_data, mk(7'd30));
            tick();
        end
        wr_ready = 1'b1;
        tick();
        chk("rel_en", wr_en, 1);
        chk("rel_addr", wr_addr, 31);
        chk("ovf_sticky", ovf_err, 1);

        // reset with entries 32..34 queued
        wr_ready = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mid_rst_en", wr_en, 0);
        chk("mid_rst_idle", idle, 1);
        chk("mid_rst_ovf", ovf_err, 0);
        wr_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (wr_en) seen = 1'b1;
            tick();
        end
        chk("mid_rst_no_write", seen, 0);

        // full FIFO with simultaneous push and pop
        do_reset();
        wr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_curr(1'b1, 7'(50 + i));
            tick();
        end
        chk("full_stall", stall, 1);
        chk("full_ovf0", ovf_err, 0);
        wr_ready = 1'b1;
        set_curr(1'b1, 7'd55);
        tick();
        set_curr(1'b0, 7'd0);
        chk("pp_ovf", ovf_err, 0);
        chk("pp_stall", stall, 1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("pp_addr%0d", i), wr_addr, 51 + i);
            chk($sformatf("pp_en%0d", i), wr_en, 1);
            tick();
        end
        chk("pp_idle", idle, 1);

`ifdef STORE_ARB_PERF_EN
        do_reset();
        for (int i = 0; i < 40; i++) begin
            set_mem(i < 10, 7'(60 + i));
            wr_ready = !(i == 4 || i == 5);
            tick();
        end
        chk("perf_writes", perf_writes, 10);
        chk("perf_bp", perf_bp_cyc, 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
